// File: rtl/set_host.sv
// set_host: host-side driver for the SET candidate-counting engine.
//
// Takes one job record at a time on a valid/ready input and drives SET's
// en/central/radius/mode strobe protocol. The operands stay frozen until the
// next job is accepted. SET's one-cycle valid pulse is captured and the result
// is returned on a valid/ready port. A watchdog aborts a job that SET never
// answers.
//
// Parameters
//   EN_CYCLES  cycles set_en is held high per job (>= 1)
//   GAP        idle cycles after reset and after each job before the next set_en
//   TIMEOUT    maximum cycles spent waiting for set_valid (10-bit counter)
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   job_valid      job record present
//   job_ready      block accepts a job this cycle
//   job_data[37:0] {central[23:0], radius[11:0], mode[1:0]}
//   set_en         SET input strobe
//   set_central    SET central operand {ax,ay,bx,by,cx,cy}
//   set_radius     SET radius operand {ar,br,cr}
//   set_mode       SET mode operand
//   set_busy       SET busy (holds off job_ready while idle)
//   set_valid      SET one-cycle result strobe
//   set_candidate  SET result
//   res_valid      result held
//   res_ready      consumer takes the result
//   res_data       captured candidate (0 on timeout)
//   res_err        result is a timeout abort
//   jobs_done      completed non-error jobs, wrapping
//   timeout_flag   sticky timeout indicator, cleared only by reset
//
// Every output is a flop, so none of them follows an input combinationally.

module set_host #(
  parameter int unsigned EN_CYCLES = 1,
  parameter int unsigned GAP       = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [37:0] job_data,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_err,
  output logic [15:0] jobs_done,
  output logic        timeout_flag
);

  // Terminal value of the wait counter. The counter starts at 0 on the first
  // WAIT cycle, so an abort lands exactly TIMEOUT cycles after WAIT is entered.
  localparam logic [9:0] WaitLast = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StGapw,
    StIdle,
    StLoad,
    StWait,
    StResp
  } state_e;

  state_e      state_q;
  logic [15:0] gap_cnt_q;
  logic [15:0] en_cnt_q;
  logic [9:0]  wait_cnt_q;

  logic gap_done;
  logic en_done;
  logic accept;

  // GAPW lasts GAP cycles. The state is left on the edge that closes the last
  // gap cycle. A GAP of 0 still spends one cycle in GAPW.
  assign gap_done = (32'(gap_cnt_q) + 32'd1) >= GAP;
  assign en_done  = (32'(en_cnt_q) + 32'd1) >= EN_CYCLES;
  assign accept   = (state_q == StIdle) && job_valid && job_ready;

  // Operand registers. These change only on job acceptance. SET reads them
  // combinationally for the whole computation, so they must not move during
  // LOAD, WAIT, RESP or GAPW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
    end else if (accept) begin
      set_central <= job_data[37:14];
      set_radius  <= job_data[13:2];
      set_mode    <= job_data[1:0];
    end
  end

  // Control FSM. It also holds all of the registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StGapw;
      gap_cnt_q    <= '0;
      en_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      job_ready    <= 1'b0;
      set_en       <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_err      <= 1'b0;
      jobs_done    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state_q)
        StGapw: begin
          if (gap_done) begin
            state_q   <= StIdle;
            job_ready <= !set_busy;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end

        StIdle: begin
          if (accept) begin
            state_q   <= StLoad;
            job_ready <= 1'b0;
            set_en    <= 1'b1;
            en_cnt_q  <= '0;
          end else begin
            // A busy SET holds off new work. The effect shows one cycle later.
            job_ready <= !set_busy;
          end
        end

        StLoad: begin
          if (en_done) begin
            state_q    <= StWait;
            set_en     <= 1'b0;
            wait_cnt_q <= '0;
          end else begin
            en_cnt_q <= en_cnt_q + 16'd1;
          end
        end

        StWait: begin
          // A valid result takes priority over a timeout in the same cycle.
          if (set_valid) begin
            state_q   <= StResp;
            res_valid <= 1'b1;
            res_data  <= set_candidate;
            res_err   <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
          end else if (wait_cnt_q == WaitLast) begin
            state_q      <= StResp;
            res_valid    <= 1'b1;
            res_data     <= '0;
            res_err      <= 1'b1;
            timeout_flag <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 10'd1;
          end
        end

        StResp: begin
          if (res_ready) begin
            state_q   <= StGapw;
            res_valid <= 1'b0;
            gap_cnt_q <= '0;
          end
        end

        default: begin
          state_q   <= StGapw;
          gap_cnt_q <= '0;
          job_ready <= 1'b0;
          set_en    <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_host.sv
module tb_set_host;

  localparam int unsigned EnCycles = 2;
  localparam int unsigned Gap      = 2;
  localparam int unsigned Timeout  = 16;
  localparam int          Lat      = 8;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [37:0] job_data;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_err;
  logic [15:0] jobs_done;
  logic        timeout_flag;

  set_host #(
    .EN_CYCLES(EnCycles),
    .GAP      (Gap),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_data     (job_data),
    .set_en       (set_en),
    .set_central  (set_central),
    .set_radius   (set_radius),
    .set_mode     (set_mode),
    .set_busy     (set_busy),
    .set_valid    (set_valid),
    .set_candidate(set_candidate),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_err      (res_err),
    .jobs_done    (jobs_done),
    .timeout_flag (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];   // {err, data}
  int         exp_done = 0;

  // Control written only by the main process.
  bit          mute = 1'b0;
  int          spur_req = 0;
  bit          stab_on = 1'b0;
  logic [37:0] stab_ref = '0;

  // State written only by the SET model and the monitors.
  int spur_done   = 0;
  int stab_viol   = 0;
  int en_res_viol = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Candidate count over the 8x8 grid (coordinates 1..8).
  function automatic logic [7:0] set_count(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
    int ax, ay, bx, by, cx, cy, ar, br, cr, cnt;
    bit ia, ib, ic, hit;
    ax = int'(c[23:20]); ay = int'(c[19:16]); bx = int'(c[15:12]);
    by = int'(c[11:8]);  cx = int'(c[7:4]);   cy = int'(c[3:0]);
    ar = int'(r[11:8]);  br = int'(r[7:4]);   cr = int'(r[3:0]);
    cnt = 0;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        ia = ((x - ax) * (x - ax) + (y - ay) * (y - ay)) <= ar * ar;
        ib = ((x - bx) * (x - bx) + (y - by) * (y - by)) <= br * br;
        ic = ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= cr * cr;
        case (m)
          2'd0:    hit = ia;
          2'd1:    hit = ia && ib;
          2'd2:    hit = ia != ib;
          default: hit = (int'(ia) + int'(ib) + int'(ic)) == 2;
        endcase
        if (hit) cnt++;
      end
    end
    return 8'(cnt);
  endfunction

  function automatic logic [37:0] mk_job(input int ax, input int ay, input int bx, input int by,
                                         input int cx, input int cy, input int ar, input int br,
                                         input int cr, input int m);
    return {4'(ax), 4'(ay), 4'(bx), 4'(by), 4'(cx), 4'(cy), 4'(ar), 4'(br), 4'(cr), 2'(m)};
  endfunction

  // Behavioural SET: starts on the falling edge of en, and answers Lat cycles
  // later from the operands it sees at that time.
  initial begin
    bit en_prev;
    bit pending;
    int lat;
    en_prev = 1'b0;
    pending = 1'b0;
    lat = 0;
    set_valid = 1'b0;
    set_busy = 1'b0;
    set_candidate = '0;
    forever begin
      @(negedge clk);
      set_valid = 1'b0;
      if (en_prev && !set_en && !mute) begin
        pending = 1'b1;
        lat = Lat;
      end else if (pending) begin
        lat--;
        if (lat == 0) begin
          pending = 1'b0;
          set_valid = 1'b1;
          set_candidate = set_count(set_central, set_radius, set_mode);
        end
      end
      if (spur_done != spur_req) begin
        set_valid = 1'b1;
        set_candidate = 8'h5A;
        spur_done++;
      end
      set_busy = pending;
      en_prev = set_en;
    end
  end

  // Monitors.
  always @(negedge clk) begin
    if (set_en && res_valid) en_res_viol <= en_res_viol + 1;
    if (stab_on && ({set_central, set_radius, set_mode} != stab_ref)) stab_viol <= stab_viol + 1;
  end

  task automatic send_job(input logic [37:0] d, input bit push, input logic [8:0] exp);
    int n;
    n = 0;
    while (!job_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) begin
      check("job_ready_wait", job_ready, 1);
      return;
    end
    job_valid = 1'b1;
    job_data = d;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic consume(input int hold);
    int n;
    logic [8:0] e;
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      check("res_valid_wait", res_valid, 1);
      return;
    end
    repeat (hold) @(negedge clk);
    check("res_valid_held", res_valid, 1);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 64'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      check("res_data", res_data, e[7:0]);
      check("res_err", res_err, e[8]);
      if (!e[8]) exp_done++;
    end
    check("jobs_done", jobs_done, 16'(exp_done));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic count_ready_delay(output int n);
    n = 0;
    while (!job_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [37:0] j1, j2, j;
    int n;
    rst = 1'b0;
    job_valid = 1'b0;
    job_data = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_job_ready", job_ready, 0);
    check("rst_set_en", set_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    check("rst_operands", {set_central, set_radius, set_mode}, 0);

    rst = 1'b1;
    count_ready_delay(n);
    check("first_ready_delay", 64'(n), Gap);

    // Single job, mode 0, A=(4,4) r=3.
    j = mk_job(4, 4, 0, 0, 0, 0, 3, 0, 0, 0);
    send_job(j, 1'b1, {1'b0, 8'd29});
    n = 0;
    while (set_en && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("en_pulse_len", 64'(n), EnCycles);
    consume(0);

    // Operand stability: a second job is held on the input all the way through.
    j1 = mk_job(3, 3, 5, 5, 0, 0, 2, 3, 0, 2);
    j2 = mk_job(6, 2, 2, 6, 4, 4, 4, 2, 3, 1);
    send_job(j1, 1'b1, {1'b0, set_count(j1[37:14], j1[13:2], j1[1:0])});
    stab_ref = j1;
    stab_on = 1'b1;
    job_valid = 1'b1;
    job_data = j2;
    consume(3);
    n = 1;
    while (!job_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    stab_on = 1'b0;
    check("ready_after_resp", 64'(n), Gap + 1);
    check("operand_stable", 64'(stab_viol), 0);
    exp_q.push_back({1'b0, set_count(j2[37:14], j2[13:2], j2[1:0])});
    @(negedge clk);
    job_valid = 1'b0;
    check("operands_j2", {set_central, set_radius, set_mode}, j2);
    consume(0);

    // Eight jobs, modes 0..3, 5 cycles of backpressure on each result.
    for (int i = 0; i < 8; i++) begin
      j = mk_job($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8),
                 $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8),
                 $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5), i % 4);
      send_job(j, 1'b1, {1'b0, set_count(j[37:14], j[13:2], j[1:0])});
      consume(5);
    end
    check("jobs_done_b2b", jobs_done, 16'd11);
    check("no_en_during_res", 64'(en_res_viol), 0);

    // Spurious set_valid in GAPW (directly after the handshake) and in IDLE.
    spur_req++;
    repeat (2) @(negedge clk);
    n = 0;
    while (!job_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    spur_req++;
    repeat (4) @(negedge clk);
    check("spur_jobs_done", jobs_done, 16'(exp_done));
    check("spur_res_valid", res_valid, 0);

    // Timeout: SET never answers.
    check("timeout_flag_pre", timeout_flag, 0);
    mute = 1'b1;
    j = mk_job(2, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    send_job(j, 1'b1, {1'b1, 8'h00});
    n = 0;
    while (set_en && n < 20) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!res_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_latency", 64'(n), Timeout);
    check("timeout_flag", timeout_flag, 1);
    consume(0);

    // Reset in the middle of WAIT.
    send_job(j, 1'b0, '0);
    n = 0;
    while (set_en && n < 20) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_job_ready", job_ready, 0);
    check("mid_rst_set_en", set_en, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_err", res_err, 0);
    check("mid_rst_jobs_done", jobs_done, 0);
    check("mid_rst_timeout_flag", timeout_flag, 0);
    check("mid_rst_operands", {set_central, set_radius, set_mode}, 0);
    exp_done = 0;
    @(negedge clk);
    rst = 1'b1;
    count_ready_delay(n);
    check("rst_ready_delay", 64'(n), Gap);
    check("rst_timeout_cleared", timeout_flag, 0);

    // Recovery job after the reset.
    mute = 1'b0;
    j = mk_job(5, 5, 4, 4, 3, 6, 3, 3, 2, 3);
    send_job(j, 1'b1, {1'b0, set_count(j[37:14], j[13:2], j[1:0])});
    consume(1);

    check("sb_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
